// File: rtl/eth_phy_10g_tx_if_if.sv
// Encoder-to-SERDES block bus of the 10GBASE-R PCS transmit back-end.
// master = encoder/test side, slave = eth_phy_10g_tx_if.
interface eth_phy_10g_tx_if_if #(
   parameter int DATA_WIDTH = 64,
   parameter int HDR_WIDTH  = 2
);
   logic [DATA_WIDTH-1:0] encoded_tx_data;
   logic [HDR_WIDTH-1:0]  encoded_tx_hdr;
   logic [DATA_WIDTH-1:0] serdes_tx_data;
   logic [HDR_WIDTH-1:0]  serdes_tx_hdr;
   logic                  tx_bad_block;
   logic [7:0]            tx_bad_block_count;

   modport master (
      output encoded_tx_data, encoded_tx_hdr,
      input  serdes_tx_data, serdes_tx_hdr, tx_bad_block, tx_bad_block_count
   );

   modport slave (
      input  encoded_tx_data, encoded_tx_hdr,
      output serdes_tx_data, serdes_tx_hdr, tx_bad_block, tx_bad_block_count
   );
endinterface

// File: rtl/eth_phy_10g_tx_if.sv
// 10GBASE-R TX back-end: x^58+x^39+1 scrambler, header check, optional PRBS31 (ETH_PHY_10G_TX_PRBS31_EN).
// Latency 1 + SERDES_PIPELINE cycles; tx_bad_block is aligned with stage 1 only.
// No backpressure: one block per clock, every register stage shifts every cycle.
module eth_phy_10g_tx_if #(
   parameter int DATA_WIDTH        = 64,
   parameter int HDR_WIDTH         = 2,
   parameter int BIT_REVERSE       = 0,
   parameter int SCRAMBLER_DISABLE = 0,
   parameter int SERDES_PIPELINE   = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   eth_phy_10g_tx_if_if.slave tx
`ifdef ETH_PHY_10G_TX_PRBS31_EN
   ,
   input  logic               cfg_tx_prbs31_enable
`endif
);

   localparam int PW = DATA_WIDTH + HDR_WIDTH;

   if (DATA_WIDTH != 64) begin : g_bad_data_width
      $error("eth_phy_10g_tx_if: DATA_WIDTH must be 64");
   end
   if (HDR_WIDTH != 2) begin : g_bad_hdr_width
      $error("eth_phy_10g_tx_if: HDR_WIDTH must be 2");
   end
   if (SERDES_PIPELINE < 0 || SERDES_PIPELINE > 4) begin : g_bad_pipe
      $error("eth_phy_10g_tx_if: SERDES_PIPELINE must be 0..4");
   end

   logic [57:0]           scr_state;
   logic [57:0]           scr_state_nxt;
   logic [DATA_WIDTH-1:0] scr_data;
   logic [DATA_WIDTH-1:0] ld_data;
   logic [HDR_WIDTH-1:0]  ld_hdr;
   logic                  ld_bad;
   logic [DATA_WIDTH-1:0] s1_data;
   logic [HDR_WIDTH-1:0]  s1_hdr;
   logic [DATA_WIDTH-1:0] rev_data;
   logic [HDR_WIDTH-1:0]  rev_hdr;
   logic                  bad_q;
   logic [7:0]            bad_cnt_q;

   // Serial self-synchronizing scrambler unrolled over the whole block, bit 0 first.
   always_comb begin
      logic [57:0] s;
      s        = scr_state;
      scr_data = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         scr_data[i] = tx.encoded_tx_data[i] ^ s[38] ^ s[57];
         s           = {s[56:0], scr_data[i]};
      end
      scr_state_nxt = s;
   end

`ifdef ETH_PHY_10G_TX_PRBS31_EN
   logic [30:0] prbs_state;
   logic [30:0] prbs_state_nxt;
   logic [PW-1:0] prbs_word;

   // 66 generator steps per block; header takes the first two emitted bits.
   always_comb begin
      logic [30:0] p;
      logic        b;
      p         = prbs_state;
      b         = 1'b0;
      prbs_word = '0;
      for (int i = 0; i < PW; i++) begin
         b            = p[30] ^ p[27];
         p            = {p[29:0], b};
         prbs_word[i] = ~b;
      end
      prbs_state_nxt = p;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prbs_state <= '1;
      end else if (cfg_tx_prbs31_enable) begin
         prbs_state <= prbs_state_nxt;
      end
   end
`endif

   always_comb begin
      ld_data = (SCRAMBLER_DISABLE != 0) ? tx.encoded_tx_data : scr_data;
      ld_hdr  = tx.encoded_tx_hdr;
      ld_bad  = (tx.encoded_tx_hdr == 2'b00) || (tx.encoded_tx_hdr == 2'b11);
`ifdef ETH_PHY_10G_TX_PRBS31_EN
      if (cfg_tx_prbs31_enable) begin
         ld_data = prbs_word[PW-1:HDR_WIDTH];
         ld_hdr  = prbs_word[HDR_WIDTH-1:0];
         ld_bad  = 1'b0;
      end
`endif
   end

   // Scrambler keeps running under PRBS so the encoder stream resumes seamlessly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scr_state <= '1;
         s1_data   <= '0;
         s1_hdr    <= '0;
         bad_q     <= 1'b0;
         bad_cnt_q <= '0;
      end else begin
         if (SCRAMBLER_DISABLE == 0) begin
            scr_state <= scr_state_nxt;
         end
         s1_data <= ld_data;
         s1_hdr  <= ld_hdr;
         bad_q   <= ld_bad;
         if (ld_bad && (bad_cnt_q != 8'hFF)) begin
            bad_cnt_q <= bad_cnt_q + 8'd1;
         end
      end
   end

   always_comb begin
      rev_data = s1_data;
      rev_hdr  = s1_hdr;
      if (BIT_REVERSE != 0) begin
         for (int i = 0; i < DATA_WIDTH; i++) begin
            rev_data[i] = s1_data[DATA_WIDTH-1-i];
         end
         for (int i = 0; i < HDR_WIDTH; i++) begin
            rev_hdr[i] = s1_hdr[HDR_WIDTH-1-i];
         end
      end
   end

   if (SERDES_PIPELINE == 0) begin : g_no_pipe
      assign tx.serdes_tx_data = rev_data;
      assign tx.serdes_tx_hdr  = rev_hdr;
   end else begin : g_pipe
      logic [DATA_WIDTH-1:0] pipe_data [SERDES_PIPELINE];
      logic [HDR_WIDTH-1:0]  pipe_hdr  [SERDES_PIPELINE];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int i = 0; i < SERDES_PIPELINE; i++) begin
               pipe_data[i] <= '0;
               pipe_hdr[i]  <= '0;
            end
         end else begin
            pipe_data[0] <= rev_data;
            pipe_hdr[0]  <= rev_hdr;
            for (int i = 1; i < SERDES_PIPELINE; i++) begin
               pipe_data[i] <= pipe_data[i-1];
               pipe_hdr[i]  <= pipe_hdr[i-1];
            end
         end
      end

      assign tx.serdes_tx_data = pipe_data[SERDES_PIPELINE-1];
      assign tx.serdes_tx_hdr  = pipe_hdr[SERDES_PIPELINE-1];
   end

   assign tx.tx_bad_block       = bad_q;
   assign tx.tx_bad_block_count = bad_cnt_q;

endmodule

// File: tb/tb_eth_phy_10g_tx_if.sv
// Directed bench: three configurations (default, 2-stage pipeline, bit-reverse + scrambler bypass)
// share one stimulus stream; expected values are hand-derived or from independent reference checkers.
module tb_eth_phy_10g_tx_if;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] in_data;
   logic [1:0]  in_hdr;
   logic        cfg;
   int          n_vec = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   eth_phy_10g_tx_if_if bus0 ();
   eth_phy_10g_tx_if_if bus1 ();
   eth_phy_10g_tx_if_if bus2 ();

   assign bus0.encoded_tx_data = in_data;
   assign bus0.encoded_tx_hdr  = in_hdr;
   assign bus1.encoded_tx_data = in_data;
   assign bus1.encoded_tx_hdr  = in_hdr;
   assign bus2.encoded_tx_data = in_data;
   assign bus2.encoded_tx_hdr  = in_hdr;

   eth_phy_10g_tx_if u_dut0 (
      .clk                  (clk),
      .rst_n                (rst_n),
      .tx                   (bus0.slave)
`ifdef ETH_PHY_10G_TX_PRBS31_EN
      ,.cfg_tx_prbs31_enable(cfg)
`endif
   );

   eth_phy_10g_tx_if #(.SERDES_PIPELINE(2)) u_dut1 (
      .clk                  (clk),
      .rst_n                (rst_n),
      .tx                   (bus1.slave)
`ifdef ETH_PHY_10G_TX_PRBS31_EN
      ,.cfg_tx_prbs31_enable(cfg)
`endif
   );

   eth_phy_10g_tx_if #(.BIT_REVERSE(1), .SCRAMBLER_DISABLE(1)) u_dut2 (
      .clk                  (clk),
      .rst_n                (rst_n),
      .tx                   (bus2.slave)
`ifdef ETH_PHY_10G_TX_PRBS31_EN
      ,.cfg_tx_prbs31_enable(cfg)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] rev64(input logic [63:0] v);
      logic [63:0] r;
      for (int i = 0; i < 64; i++) r[i] = v[63-i];
      return r;
   endfunction

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   // Bench-side state: reference descrambler and PRBS31 checker history
   logic [57:0] dsc;
   logic [30:0] ph;
   int          pbits;
   int          perr;

   task automatic prbs_check_block(input logic [63:0] d, input logic [1:0] h);
      logic [65:0] w;
      logic        e;
      w = {d, h};
      for (int i = 0; i < 66; i++) begin
         e = w[i];
         if (pbits >= 31 && e !== ~(ph[30] ^ ph[27])) perr++;
         ph = {ph[29:0], e};
         pbits++;
      end
   endtask

   initial begin
      logic        exp_bad;
      int          exp_cnt;
      logic [1:0]  hseq [$];
      logic [63:0] hist_d [$];
      logic [1:0]  hist_h [$];
      logic [63:0] o;
      logic [63:0] rec;
      int          rt_derr, rt_herr, rev_err, rt_n;

      // Reset with random inputs
      rst_n   = 1'b0;
      cfg     = 1'b0;
      for (int k = 0; k < 4; k++) begin
         in_data = rnd64();
         in_hdr  = 2'($urandom_range(0, 3));
         step();
      end
      chk("rst_data",  bus0.serdes_tx_data, 64'h0);
      chk("rst_hdr",   64'(bus0.serdes_tx_hdr), 64'h0);
      chk("rst_bad",   64'(bus0.tx_bad_block), 64'h0);
      chk("rst_cnt",   64'(bus0.tx_bad_block_count), 64'h0);
      chk("rst_data1", bus1.serdes_tx_data, 64'h0);

      // Scrambler seed and bit reverse
      in_data = 64'h0;
      in_hdr  = 2'b10;
      rst_n   = 1'b1;
      step();
      chk("seed_data", bus0.serdes_tx_data, 64'h03FF_FF80_0000_0000);
      chk("seed_hdr",  64'(bus0.serdes_tx_hdr), 64'h2);
      chk("rev0_hdr",  64'(bus2.serdes_tx_hdr), 64'h1);
      in_data = 64'h1;
      in_hdr  = 2'b01;
      step();
      chk("rev_data", bus2.serdes_tx_data, 64'h8000_0000_0000_0000);
      chk("rev_hdr",  64'(bus2.serdes_tx_hdr), 64'h2);
      chk("pass_hdr", 64'(bus0.serdes_tx_hdr), 64'h1);

      // Reset mid-stream clears outputs without waiting for a clock
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_hdr",  64'(bus0.serdes_tx_hdr), 64'h0);
      chk("mid_rst_data", bus2.serdes_tx_data, 64'h0);
      rst_n   = 1'b1;
      in_data = 64'h0;
      in_hdr  = 2'b10;
      step();
      chk("reseed_data", bus0.serdes_tx_data, 64'h03FF_FF80_0000_0000);

      // Bad headers: 00, 11, 01, 300 x 11, then 01
      #1 rst_n = 1'b0;
      #1 rst_n = 1'b1;
      hseq.push_back(2'b00);
      hseq.push_back(2'b11);
      hseq.push_back(2'b01);
      for (int k = 0; k < 300; k++) hseq.push_back(2'b11);
      hseq.push_back(2'b01);
      exp_cnt = 0;
      foreach (hseq[k]) begin
         in_data = rnd64();
         in_hdr  = hseq[k];
         step();
         exp_bad = (hseq[k] == 2'b00) || (hseq[k] == 2'b11);
         if (exp_bad && exp_cnt < 255) exp_cnt++;
         chk("bad_pulse",  64'(bus0.tx_bad_block), 64'(exp_bad));
         chk("bad_pulse1", 64'(bus1.tx_bad_block), 64'(exp_bad));
         chk("bad_hdr",    64'(bus0.serdes_tx_hdr), 64'(hseq[k]));
         chk("bad_cnt",    64'(bus0.tx_bad_block_count), 64'(exp_cnt));
      end
      chk("bad_cnt_sat", 64'(bus0.tx_bad_block_count), 64'd255);

      // Round trip through a reference descrambler at latency 3
      #1 rst_n = 1'b0;
      #1 rst_n = 1'b1;
      dsc = '1;
      rt_derr = 0; rt_herr = 0; rev_err = 0; rt_n = 0;
      for (int k = 0; k < 10000; k++) begin
         in_data = rnd64();
         in_hdr  = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
         hist_d.push_back(in_data);
         hist_h.push_back(in_hdr);
         step();
         if (bus2.serdes_tx_data !== rev64(in_data) ||
             bus2.serdes_tx_hdr !== {in_hdr[0], in_hdr[1]}) rev_err++;
         if (k >= 2) begin
            o = bus1.serdes_tx_data;
            for (int i = 0; i < 64; i++) begin
               rec[i] = o[i] ^ dsc[38] ^ dsc[57];
               dsc    = {dsc[56:0], o[i]};
            end
            if (rec !== hist_d[k-2]) rt_derr++;
            if (bus1.serdes_tx_hdr !== hist_h[k-2]) rt_herr++;
            rt_n++;
         end
      end
      chk("rt_data_errs", 64'(rt_derr), 64'd0);
      chk("rt_hdr_errs",  64'(rt_herr), 64'd0);
      chk("rt_blocks",    64'(rt_n), 64'd9998);
      chk("rev_errs",     64'(rev_err), 64'd0);
      chk("rt_no_bad",    64'(bus0.tx_bad_block_count), 64'd0);

`ifdef ETH_PHY_10G_TX_PRBS31_EN
      // PRBS31: invalid encoder headers must not raise tx_bad_block
      rst_n = 1'b0;
      cfg   = 1'b1;
      #1 rst_n = 1'b1;
      in_hdr = 2'b00;
      ph = '0; pbits = 0; perr = 0;
      rev_err = 0; rt_derr = 0;
      for (int k = 0; k < 1000; k++) begin
         in_data = rnd64();
         step();
         if (k == 0) begin
            chk("prbs_first_hdr",  64'(bus0.serdes_tx_hdr), 64'h3);
            chk("prbs_first_data", 64'(bus0.serdes_tx_data[29:0]), 64'h23FF_FFFF);
         end
         prbs_check_block(bus0.serdes_tx_data, bus0.serdes_tx_hdr);
         if (bus0.tx_bad_block !== 1'b0) rt_derr++;
         if (bus2.serdes_tx_data !== rev64(bus0.serdes_tx_data)) rev_err++;
      end
      chk("prbs_errs",  64'(perr), 64'd0);
      chk("prbs_bits",  64'(pbits), 64'd66000);
      chk("prbs_nobad", 64'(rt_derr), 64'd0);
      chk("prbs_cnt",   64'(bus0.tx_bad_block_count), 64'd0);
      chk("prbs_rev",   64'(rev_err), 64'd0);

      // Encoder stream resumes on the next load; generator holds while disabled
      cfg     = 1'b0;
      in_data = 64'h0123_4567_89AB_CDEF;
      in_hdr  = 2'b01;
      step();
      chk("resume_hdr",  64'(bus0.serdes_tx_hdr), 64'h1);
      chk("resume_data", bus2.serdes_tx_data, rev64(64'h0123_4567_89AB_CDEF));
      chk("resume_bad",  64'(bus0.tx_bad_block), 64'h0);
      cfg  = 1'b1;
      perr = 0;
      for (int k = 0; k < 5; k++) begin
         step();
         prbs_check_block(bus0.serdes_tx_data, bus0.serdes_tx_hdr);
      end
      chk("prbs_hold_errs", 64'(perr), 64'd0);
      cfg = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/eth_phy_10g_tx_if.md
Name: eth_phy_10g_tx_if

Overview:
- 10GBASE-R PCS transmit back-end. Takes 64b/66b encoded blocks from the XGMII encoder.
- Scrambles the payload with the self-synchronizing x^58+x^39+1 polynomial and checks sync headers.
- Optionally substitutes a PRBS31 test pattern, bit-reverses, and pipelines toward the SERDES.
- Sits between the encoder and the transceiver TX gearbox; it is the transmit counterpart of the RX PCS interface.

Parameters:
DATA_WIDTH, 64, payload width; only 64 is legal (elaboration error otherwise)
HDR_WIDTH, 2, sync header width; only 2 is legal
BIT_REVERSE, 0, 1 = reverse bit order of data and of header at the output
SCRAMBLER_DISABLE, 0, 1 = bypass scrambler (payload passes unmodified; scrambler state held)
SERDES_PIPELINE, 0, number of extra output register stages (0..4)

Ports:
clk  in  1  PCS clock (one block per cycle, no valid strobe)
rst_n  in  1  asynchronous active-low reset
encoded_tx_data  in  64  encoded block payload, bit 0 transmitted first
encoded_tx_hdr  in  2  sync header: 2'b01 data, 2'b10 control, bit 0 first
serdes_tx_data  out  64  payload to SERDES
serdes_tx_hdr  out  2  header to SERDES
tx_bad_block  out  1  one-cycle pulse: invalid header (2'b00 or 2'b11) seen
tx_bad_block_count  out  8  saturating count of invalid headers
cfg_tx_prbs31_enable  in  1  present only with the optional feature

Behaviour:
- Reset (asynchronous assertion, synchronous release on clk): scrambler state = all ones (58 bits); PRBS state = all ones (31 bits); all output and pipeline registers = 0; count = 0; tx_bad_block = 0.
- Scrambler, per cycle, serial over i = 0..63:
  - out_i = in_i ^ s[38] ^ s[57]
  - s = {s[56:0], out_i}
  - The header is never scrambled.
  - The state advances every cycle, including while PRBS is selected (unless SCRAMBLER_DISABLE).
- Stage 1 register (latency 1): data = scrambled payload (or PRBS); hdr = input header (or PRBS).
- BIT_REVERSE=1: data[i] <= stage-1 data[63-i]; hdr[i] <= hdr[1-i]. Applied combinationally before the pipeline stages.
- Total latency input to serdes_tx_* = 1 + SERDES_PIPELINE cycles. Pipeline stages shift every cycle; no stall.
- Header check, registered in stage 1:
  - tx_bad_block = 1 for one cycle per invalid input header, aligned with stage-1 output.
  - Not delayed by SERDES_PIPELINE.
  - Consecutive bad headers give consecutive pulses.
  - Invalid headers are passed through unchanged.
- Counter: increments on every tx_bad_block and saturates at 255. Cleared only by reset; no wrap.
- Reset mid-stream: outputs go to 0 immediately (asynchronous). The first block after release is scrambled from the all-ones state.

Optional Feature:
- Macro: ETH_PHY_10G_TX_PRBS31_EN.
- Defined:
  - Adds cfg_tx_prbs31_enable and a 31-bit PRBS generator (x^31+x^28+1).
  - Per cycle, 66 serial steps: b = p[30]^p[27]; p = {p[29:0], b}; emitted bit = ~b.
  - Steps 0,1 form hdr[0],hdr[1]; steps 2..65 form data[0..63].
  - While cfg = 1, stage 1 loads the PRBS word instead of header/scrambled payload. BIT_REVERSE and the pipeline still apply.
  - The generator advances only while cfg = 1.
  - cfg is sampled each cycle, with no synchronizer (quasi-static, driven from the clk domain).
  - The switch takes effect on the next stage-1 load.
  - tx_bad_block is forced 0 while cfg = 1.
- Undefined: no port, no generator logic; the block always transmits the encoder stream.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> serdes_tx_data=0, serdes_tx_hdr=0, tx_bad_block=0, count=0. Deassert mid-stream, then reassert -> outputs clear the same cycle.
- Scrambler seed: after reset, data=0, hdr=2'b10, defaults -> one cycle later serdes_tx_data=64'h03FF_FF80_0000_0000, hdr=2'b10.
- Round trip: 10,000 random blocks, valid headers, SERDES_PIPELINE=2 -> a reference x^58+x^39+1 descrambler recovers inputs exactly at latency 3; headers unchanged.
- Bit reverse: BIT_REVERSE=1, SCRAMBLER_DISABLE=1, data=64'h1, hdr=2'b01 -> data=64'h8000_0000_0000_0000, hdr=2'b10 after 1 cycle.
- Bad headers: inject hdr 2'b00, 2'b11, 2'b01, then 300 consecutive 2'b11 -> pulses on cycles 1,2,4..303; count=255 saturated, no wrap.
- PRBS31 (macro defined): cfg=1 after reset -> 66-bit stream matches a reference PRBS31 (inverted) checker with zero errors over 1,000 blocks; cfg=0 -> encoder stream resumes on the next stage-1 load.
